// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. One shared glyph decoder and frame-synchronous value updates.

// Hex nibble to active-low glyph {p,g,f,e,d,c,b,a}; dp is left off (bit7 = 1).
module decoder_7seg (
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    // Pure lookup of the hex glyph.
    always_comb begin
        case (hex)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hD8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h98;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    end

endmodule

module fnd_scan_controller #(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 2,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [7:0]  seg_7,
    output logic [3:0]  com,
    output logic        frame_done
);

    localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             tick;
    logic             boundary;
    logic             boundary_q;
    logic             xfer;
    logic             in_gap;

    logic [15:0]      pend_val;
    logic [3:0]       pend_dp;
    logic             pend_flag;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;

    logic [3:0]       nibble;
    logic [7:0]       glyph;
    logic [3:0]       lz_mask;
    logic [7:0]       seg_next;

    assign tick     = enable && (cnt == CNT_MAX);
    assign boundary = tick && (idx == 2'd3);
    // Dark display takes new data immediately so re-enable never shows stale digits.
    assign xfer     = pend_flag && (!enable || boundary);

    // The anti-ghosting gap disappears entirely when BLANK_CYCLES is zero.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Slot prescaler and digit index; both parked at zero while disabled.
    always_ff @(posedge clk or posedge reset_p) begin
        // NOTE: state is written with <= so every register samples pre-edge values;
        // = here would let later statements see already-updated state.
        if (reset_p) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending register: load wins over the boundary clear of pend_flag.
    always_ff @(posedge clk or posedge reset_p) begin
        // NOTE: these are a handful of flops, not a RAM, so resetting them is free
        // and guarantees a blank-but-defined first frame.
        if (reset_p) begin
            pend_val  <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_flag <= 1'b0;
        end else if (load) begin
            pend_val  <= value;
            pend_dp   <= dp_in;
            pend_flag <= 1'b1;
        end else if (xfer) begin
            pend_flag <= 1'b0;
        end
    end

    // Shadow register: only changes on a frame boundary (or while dark).
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
        end else if (xfer) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
        end
    end

    assign nibble = 4'(shadow_val >> {idx, 2'b00});

    decoder_7seg u_decoder (
        .hex (nibble),
        .seg (glyph)
    );

    // Leading-zero mask: digit k blank when nibbles k..3 are all zero; digit 0 never.
    always_comb begin
        // NOTE: default first so no path leaves a bit unassigned (no latch).
        lz_mask = 4'b0000;
        if (LZ_BLANK) begin
            lz_mask[3] = (shadow_val[15:12] == 4'h0);
            lz_mask[2] = lz_mask[3] && (shadow_val[11:8] == 4'h0);
            lz_mask[1] = lz_mask[2] && (shadow_val[7:4] == 4'h0);
        end
    end

    // Segment pattern for the current digit, decimal point overlaid last.
    always_comb begin
        seg_next = lz_mask[idx] ? 8'hFF : glyph;
        if (shadow_dp[idx]) begin
            seg_next[7] = 1'b0;
        end
    end

    // Registered pin drivers and the frame-start pulse.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            com        <= 4'hF;
            seg_7      <= 8'hFF;
            boundary_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            boundary_q <= boundary;
            frame_done <= boundary_q && enable;
            if (enable && !in_gap) begin
                com   <= ~(4'b0001 << idx);
                seg_7 <= seg_next;
            end else begin
                com   <= 4'hF;
                seg_7 <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (SCAN_DIV=4, BLANK_CYCLES=1).
// A frame-position model predicts com/seg_7/frame_done every clock.
module tb_fnd_scan_controller;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    logic        frame_done;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg_7      (seg_7),
        .com        (com),
        .frame_done (frame_done)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string scen     = "init";

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
                                   8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: position within the frame plus pending/shown data.
    int          m_pos;
    int          last_pos;
    logic [15:0] m_shadow, m_pend;
    logic [3:0]  m_sdp, m_pdp;
    bit          m_flag, m_prev_bnd;
    logic [3:0]  exp_com;
    logic [7:0]  exp_seg;
    logic        exp_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", scen, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_shadow   = 16'h0;
        m_pend     = 16'h0;
        m_sdp      = 4'h0;
        m_pdp      = 4'h0;
        m_flag     = 1'b0;
        m_prev_bnd = 1'b0;
    endtask

    // Predict outputs after the coming edge from current inputs and model state, then advance.
    task automatic model_step();
        int         digit;
        int         phase;
        bit         bnd;
        bit         take;
        logic [7:0] seg;
        digit    = m_pos / SCAN_DIV;
        phase    = m_pos % SCAN_DIV;
        bnd      = enable && (m_pos == FRAME - 1);
        take     = m_flag && (!enable || bnd);
        last_pos = enable ? m_pos : -1;
        exp_fd   = m_prev_bnd && enable;
        if (enable && phase >= BLANK_CYCLES) begin
            if (digit > 0 && (m_shadow >> (4 * digit)) == 16'd0) seg = 8'hFF;
            else seg = glyph_tab[m_shadow[4*digit +: 4]];
            if (m_sdp[digit]) seg[7] = 1'b0;
            exp_com = ~(4'b0001 << digit);
            exp_seg = seg;
        end else begin
            exp_com = 4'hF;
            exp_seg = 8'hFF;
        end
        if (take) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
        end
        if (load) begin
            m_pend = value;
            m_pdp  = dp_in;
            m_flag = 1'b1;
        end else if (take) begin
            m_flag = 1'b0;
        end
        m_prev_bnd = bnd;
        m_pos      = enable ? (m_pos + 1) % FRAME : 0;
    endtask

    // One clock: inputs already set at the negedge, compare on the next negedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("com", com, exp_com);
        check("seg_7", seg_7, exp_seg);
        check("frame_done", frame_done, exp_fd);
        load = 1'b0;
    endtask

    task automatic run_until(input int d, input int p);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (last_pos != d * SCAN_DIV + p && n < 64);
        if (last_pos != d * SCAN_DIV + p) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: position %0d never reached, last %0d", scen, d * SCAN_DIV + p, last_pos);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        load  = 1'b1;
        value = v;
        dp_in = dp;
        cycle();
    endtask

    // Load and run until the value is on display (covers a load on the boundary itself).
    task automatic load_and_settle(input logic [15:0] v, input logic [3:0] dp);
        do_load(v, dp);
        run_until(3, SCAN_DIV - 1);
    endtask

    task automatic check_digit(input int d, input logic [7:0] seg);
        logic [3:0] c;
        run_until(d, BLANK_CYCLES);
        c = ~(4'b0001 << d);
        check($sformatf("d%0d_com", d), com, c);
        check($sformatf("d%0d_seg", d), seg_7, seg);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives.
    task automatic do_reset();
        #2 reset_p = 1'b1;
        #1;
        check("rst_com", com, 4'hF);
        check("rst_seg", seg_7, 8'hFF);
        check("rst_fd", frame_done, 1'b0);
        model_reset();
        @(negedge clk);
        reset_p = 1'b0;
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        v = 16'($urandom);
        return v >> (4 * $urandom_range(4));
    endfunction

    initial begin
        int pulses;
        int last_fd;
        reset_p = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        value   = 16'h0;
        dp_in   = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("com", com, 4'hF);
        check("seg_7", seg_7, 8'hFF);
        check("frame_done", frame_done, 1'b0);
        reset_p = 1'b0;

        scen = "full_scan";
        enable = 1'b1;
        load_and_settle(16'h12AF, 4'h0);
        check_digit(0, 8'h8E);
        check_digit(1, 8'h88);
        check_digit(2, 8'hA4);
        check_digit(3, 8'hF9);

        scen = "lz_0005";
        load_and_settle(16'h0005, 4'h0);
        check_digit(0, 8'h92);
        check_digit(1, 8'hFF);
        check_digit(2, 8'hFF);
        check_digit(3, 8'hFF);
        scen = "lz_0000";
        load_and_settle(16'h0000, 4'h0);
        check_digit(0, 8'hC0);
        check_digit(1, 8'hFF);
        scen = "lz_0105";
        load_and_settle(16'h0105, 4'h0);
        check_digit(0, 8'h92);
        check_digit(1, 8'hC0);
        check_digit(2, 8'hF9);
        check_digit(3, 8'hFF);

        scen = "dp";
        load_and_settle(16'h0200, 4'b0100);
        check_digit(1, 8'hC0);
        check_digit(2, 8'h24);
        check_digit(3, 8'hFF);

        scen = "tearing";
        load_and_settle(16'h1111, 4'h0);
        run_until(1, 1);
        do_load(16'h2222, 4'h0);
        check_digit(2, 8'hF9);
        check_digit(3, 8'hF9);
        for (int d = 0; d < 4; d++) check_digit(d, 8'hA4);

        scen = "coincident";
        run_until(3, SCAN_DIV - 2);
        do_load(16'h3333, 4'h0);
        for (int d = 0; d < 4; d++) check_digit(d, 8'hA4);
        check_digit(0, 8'hB0);

        scen = "frame_done";
        pulses  = 0;
        last_fd = -1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cycle();
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) check("period", i - last_fd, FRAME);
                last_fd = i;
                pulses++;
            end
        end
        check("pulses", pulses, 4);

        scen = "reset_mid";
        run_until(2, 2);
        check("pre_com", com, 4'b1011);
        do_reset();
        cycle();
        check("gap_com", com, 4'hF);
        cycle();
        check("first_com", com, 4'b1110);

        scen = "enable";
        load_and_settle(16'h1234, 4'h0);
        run_until(2, 2);
        enable = 1'b0;
        cycle();
        check("off_com", com, 4'hF);
        check("off_seg", seg_7, 8'hFF);
        do_load(16'h0007, 4'h0);
        repeat (3) cycle();
        enable = 1'b1;
        cycle();
        check("on_gap_com", com, 4'hF);
        cycle();
        check("on_com", com, 4'b1110);
        check("on_seg", seg_7, 8'hD8);

        scen = "random";
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 3) enable = ~enable;
            if ($urandom_range(99) < 6) begin
                load  = 1'b1;
                value = rand_value();
                dp_in = 4'($urandom);
            end
            if ($urandom_range(999) < 3) begin
                load = 1'b0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
